// File: rtl/lfsr_arbiter_if.sv
// ---------------------------------------------------------------------------
// lfsr_arbiter_if
//
// Requester-side bundle of the LFSR arbiter.
//   req      : one request line per requester, held until its gnt bit pulses
//   reseed   : single-cycle request to restart the LFSR from its seed
//   gnt      : one-hot, one-cycle grant pulse
//   rnd_data : random word belonging to the grant in the same cycle
//
// Modports:
//   master : the requester side (drives req/reseed, receives gnt/rnd_data)
//   slave  : the arbiter side
// ---------------------------------------------------------------------------
interface lfsr_arbiter_if #(
    parameter int NREQ = 4
) ();
    logic [NREQ-1:0] req;
    logic            reseed;
    logic [NREQ-1:0] gnt;
    logic [15:0]     rnd_data;

    modport master (
        output req,
        output reseed,
        input  gnt,
        input  rnd_data
    );

    modport slave (
        input  req,
        input  reseed,
        output gnt,
        output rnd_data
    );
endinterface

// File: rtl/lfsr_arbiter.sv
// ---------------------------------------------------------------------------
// lfsr_arbiter
//
// Sequences an external 16-bit LFSR and shares its output among NREQ
// requesters. For every served request the LFSR is advanced STEPS times,
// then the resulting word is handed to the winner with a one-cycle grant.
//
// Parameters:
//   NREQ  : number of requesters (2..8)
//   STEPS : LFSR shift cycles per served request (1..255)
//
// Ports:
//   clk           : system clock, rising edge
//   rst           : synchronous active-high reset
//   bus           : requester bundle (req, reseed in; gnt, rnd_data out)
//   lfsr_q        : current LFSR word
//   lfsr_max_tick : LFSR wrap indication
//   lfsr_sh_en    : registered shift enable to the LFSR
//   lfsr_rst_n    : registered active-low reset to the LFSR
//   busy          : high whenever the controller is not idle
//   wrap_cnt      : saturating count of LFSR wraps seen while shifting
//   zero_err      : sticky flag, an all-zero word was captured
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module lfsr_arbiter #(
    parameter int NREQ  = 4,
    parameter int STEPS = 16
) (
    input  logic                clk,
    input  logic                rst,
    lfsr_arbiter_if.slave       bus,
    input  logic [15:0]         lfsr_q,
    input  logic                lfsr_max_tick,
    output logic                lfsr_sh_en,
    output logic                lfsr_rst_n,
    output logic                busy,
    output logic [7:0]          wrap_cnt,
    output logic                zero_err
);

    localparam int              IDXW     = $clog2(NREQ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NREQ - 1);
    localparam logic [IDXW:0]   NREQ_W   = (IDXW + 1)'(NREQ);
    localparam logic [7:0]      STEPS_W  = 8'(STEPS);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE
    } state_t;

    state_t            state_reg;
    logic              init_cnt_reg;      // second INIT cycle marker
    logic [7:0]        step_cnt_reg;
    logic [IDXW-1:0]   ptr_reg;           // round-robin search start
    logic [IDXW-1:0]   winner_reg;
    logic [NREQ-1:0]   gnt_reg;
    logic [15:0]       rnd_data_reg;
    logic              sh_en_reg;
    logic              lfsr_rst_n_reg;
    logic              busy_reg;
    logic [7:0]        wrap_cnt_reg;
    logic              zero_err_reg;
    logic              max_tick_prev_reg;

    // -----------------------------------------------------------------------
    // Round-robin selection
    //
    // The requester granted in the current cycle has just been served and is
    // masked so that a requester still holding req for one more cycle cannot
    // win twice in a row.
    // -----------------------------------------------------------------------
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] cand_elig;
    logic [IDXW:0]   cand_sum [NREQ];
    logic [IDXW-1:0] cand_idx [NREQ];
    logic            pick_valid;
    logic [IDXW-1:0] pick_idx;

    assign eligible = bus.req & ~gnt_reg;

    // Candidate gi is the requester gi positions after the pointer, modulo NREQ.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand_sum[gi]  = {1'b0, ptr_reg} + (IDXW + 1)'(gi);
            assign cand_idx[gi]  = (cand_sum[gi] >= NREQ_W)
                                 ? IDXW'(cand_sum[gi] - NREQ_W)
                                 : cand_sum[gi][IDXW-1:0];
            assign cand_elig[gi] = eligible[cand_idx[gi]];
        end
    endgenerate

    // Walk the candidates from the far end so the closest one to the pointer
    // is the last to be written and therefore wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_elig[i]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx[i];
            end
        end
    end

    logic [IDXW-1:0] ptr_after_winner;
    logic [NREQ-1:0] winner_onehot;

    assign ptr_after_winner = (winner_reg == LAST_IDX) ? '0 : winner_reg + IDXW'(1);
    assign winner_onehot    = ONE_HOT0 << winner_reg;

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_INIT;
            init_cnt_reg      <= 1'b0;
            step_cnt_reg      <= '0;
            ptr_reg           <= '0;
            winner_reg        <= '0;
            gnt_reg           <= '0;
            rnd_data_reg      <= '0;
            sh_en_reg         <= 1'b0;
            lfsr_rst_n_reg    <= 1'b0;
            busy_reg          <= 1'b1;
            wrap_cnt_reg      <= '0;
            zero_err_reg      <= 1'b0;
            max_tick_prev_reg <= 1'b0;
        end else begin
            // Wrap counting only while this block is actually shifting the
            // LFSR; a tick level that rises while idle is not a real wrap.
            max_tick_prev_reg <= lfsr_max_tick;
            if (lfsr_max_tick && !max_tick_prev_reg && sh_en_reg &&
                (wrap_cnt_reg != 8'hFF)) begin
                wrap_cnt_reg <= wrap_cnt_reg + 8'd1;
            end

            // Grant is a single-cycle pulse.
            gnt_reg <= '0;

            case (state_reg)
                ST_INIT: begin
                    // LFSR reset is held for exactly two cycles.
                    if (init_cnt_reg) begin
                        init_cnt_reg   <= 1'b0;
                        lfsr_rst_n_reg <= 1'b1;
                        busy_reg       <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end else begin
                        init_cnt_reg   <= 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (bus.reseed) begin
                        init_cnt_reg   <= 1'b0;
                        lfsr_rst_n_reg <= 1'b0;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_INIT;
                    end else if (pick_valid) begin
                        winner_reg     <= pick_idx;
                        step_cnt_reg   <= STEPS_W;
                        sh_en_reg      <= 1'b1;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // Counter value 1 marks the last enabled cycle, giving
                    // exactly STEPS cycles of sh_en.
                    if (step_cnt_reg == 8'd1) begin
                        step_cnt_reg   <= '0;
                        sh_en_reg      <= 1'b0;
                        state_reg      <= ST_CAPTURE;
                    end else begin
                        step_cnt_reg   <= step_cnt_reg - 8'd1;
                    end
                end

                ST_CAPTURE: begin
                    if (lfsr_q == 16'h0000) begin
                        // Locked-up LFSR: restart it and serve the same
                        // winner afterwards. The pointer is left alone so the
                        // winner is still first in line after re-init.
                        zero_err_reg   <= 1'b1;
                        init_cnt_reg   <= 1'b0;
                        lfsr_rst_n_reg <= 1'b0;
                        state_reg      <= ST_INIT;
                    end else begin
                        rnd_data_reg   <= lfsr_q;
                        gnt_reg        <= winner_onehot;
                        ptr_reg        <= ptr_after_winner;
                        busy_reg       <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end

                default: begin
                    init_cnt_reg   <= 1'b0;
                    sh_en_reg      <= 1'b0;
                    lfsr_rst_n_reg <= 1'b0;
                    busy_reg       <= 1'b1;
                    state_reg      <= ST_INIT;
                end
            endcase
        end
    end

    assign lfsr_sh_en   = sh_en_reg;
    assign lfsr_rst_n   = lfsr_rst_n_reg;
    assign busy         = busy_reg;
    assign wrap_cnt     = wrap_cnt_reg;
    assign zero_err     = zero_err_reg;
    assign bus.gnt      = gnt_reg;
    assign bus.rnd_data = rnd_data_reg;

endmodule
